// File: rtl/ha_array_accumulator_if.sv
// rtl/ha_array_accumulator_if.sv - row-set input and product output handshake bundle
interface ha_array_accumulator_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  ha_array_0_b;
   logic [6:0]  ha_array_1_b;
   logic [6:0]  ha_array_2_b;
   logic [6:0]  ha_array_3_b;
   logic [8:0]  ha_array_0_t;
   logic [8:0]  ha_array_1_t;
   logic [8:0]  ha_array_2_t;
   logic [8:0]  ha_array_3_t;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        overflow;

   modport master (
      output in_valid,
      output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
      output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  product,
      input  overflow
   );

   modport slave (
      input  in_valid,
      input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
      input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
      input  out_ready,
      output in_ready,
      output out_valid,
      output product,
      output overflow
   );
endinterface

// File: rtl/ha_array_accumulator.sv
// rtl/ha_array_accumulator.sv - sums weighted half-adder-array rows into a 16-bit product
module ha_array_accumulator #(
   parameter int ROWS_PER_CYCLE = 1
) (
   input logic                   clk,
   input logic                   rst,
   ha_array_accumulator_if.slave bus
);
   localparam int         NGROUPS  = 4 / ROWS_PER_CYCLE;
   localparam logic [1:0] LAST_GRP = 2'(NGROUPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [1:0]  grp_cnt;
   logic [8:0]  t_q [4];
   logic [6:0]  b_q [4];
   logic [16:0] acc;
   logic [16:0] grp_sum;
   logic [9:0]  row_val;
   int          row_idx;

   // Rows of the current group, each R_k = T_k + 4*B_k placed at weight 4^k.
   always_comb begin
      grp_sum = '0;
      row_val = '0;
      row_idx = 0;
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
         row_idx = int'(grp_cnt) * ROWS_PER_CYCLE + j;
         row_val = {1'b0, t_q[row_idx[1:0]]} + {1'b0, b_q[row_idx[1:0]], 2'b00};
         grp_sum = grp_sum + ({7'b0, row_val} << (2 * row_idx));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grp_cnt <= '0;
         acc     <= '0;
         for (int i = 0; i < 4; i++) begin
            t_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  t_q[0]  <= bus.ha_array_0_t;
                  t_q[1]  <= bus.ha_array_1_t;
                  t_q[2]  <= bus.ha_array_2_t;
                  t_q[3]  <= bus.ha_array_3_t;
                  b_q[0]  <= bus.ha_array_0_b;
                  b_q[1]  <= bus.ha_array_1_b;
                  b_q[2]  <= bus.ha_array_2_b;
                  b_q[3]  <= bus.ha_array_3_b;
                  acc     <= '0;
                  grp_cnt <= '0;
                  state   <= ACC;
               end
            end
            ACC: begin
               acc     <= acc + grp_sum;
               grp_cnt <= grp_cnt + 2'd1;
               if (grp_cnt == LAST_GRP) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Gated by rst so the reset cycle itself never advertises readiness.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.product   = acc[15:0];
   assign bus.overflow  = acc[16];
endmodule

// File: doc/ha_array_accumulator.md
# ha_array_accumulator

Sequential back end for the unsigned 8x8 half-adder-array multiplier front ends. It accepts the four compressed partial-product row pairs `ha_array_k_b` and `ha_array_k_t` through a valid/ready handshake. It sums them with their row weights over one or more cycles and returns the 16-bit product plus an overflow flag through a second valid/ready handshake. This block is the consumer that turns the front end's approximate row arrays into a final product word.

## Interface
- `ROWS_PER_CYCLE`, default 1: rows added per accumulate cycle. Legal values are 1, 2 and 4; any other value is illegal. ACC length = 4 / ROWS_PER_CYCLE cycles.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  the row set on the `ha_array_*` inputs is valid.
- `in_ready`  out  1  block can accept a row set.
- `ha_array_0_b` .. `ha_array_3_b`  in  7 each  carry vectors. Bit i has weight 2^(i+2) within its row.
- `ha_array_0_t` .. `ha_array_3_t`  in  9 each  sum vectors. Bit i has weight 2^i within its row.
- `out_valid`  out  1  `product` and `overflow` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `product`  out  16  low 16 bits of the accumulated sum.
- `overflow`  out  1  accumulated sum is ≥ 2^16.

## Operation
- Row value: R_k = T_k + 4·B_k, which is at most 1019 and fits 10 bits. Result: S = Σ R_k·4^k for k = 0..3, accumulated in 17 bits. Maximum S = 86615.
- States:
  - **IDLE**: `in_ready`=1. On `in_valid`&`in_ready`, register all 64 input bits, clear the accumulator, clear the row counter, go to ACC.
  - **ACC**: each cycle, add the next ROWS_PER_CYCLE rows, each shifted left by 2k, then increment the counter. After the last group, go to DONE.
  - **DONE**: `out_valid`=1. `product` = S[15:0], `overflow` = S[16]. Hold both stable until `out_valid`&`out_ready`, then go to IDLE.
- Inputs are sampled only on the accept edge. Changes on `ha_array_*` during ACC or DONE have no effect.
- `in_ready` is 0 in ACC and DONE. An `in_valid` asserted during those states is not accepted; the upstream source must hold it.
- Upstream row arrays are taken as-is. No consistency check between t and b is performed, so arbitrary bit patterns are legal and may set `overflow`.
- Reset at any time, including mid-ACC or in DONE: go to IDLE, discard the row set in flight and any pending result, no output handshake.
- Reset values: `in_ready`=0 during the reset cycle and 1 on the first cycle after reset deasserts. `out_valid`=0, `product`=16'h0000, `overflow`=0.

## Timing
- Accept edge E0 is the edge where `in_valid`&`in_ready` is high.
- ROWS_PER_CYCLE=1: ACC spans E1..E4, and `out_valid` rises in the cycle after E4.
- ROWS_PER_CYCLE=2: result after E2. ROWS_PER_CYCLE=4: result after E1.
- Output handshake edge returns the block to IDLE. `in_ready`=1 in the following cycle.
- Minimum spacing between accepts is ACC length + 2 cycles: 6 for ROWS_PER_CYCLE=1, 3 for ROWS_PER_CYCLE=4.
- `out_valid` never drops without a handshake, except on `rst`.
- There is no combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.

## Test plan
- Reset then idle → `in_ready`=1, `out_valid`=0, `product`=0, `overflow`=0.
- All four rows t=9'h001, b=0, `out_ready`=1 → `product`=85 (16'h0055), `overflow`=0, `out_valid` after exactly 4 edges for ROWS_PER_CYCLE=1, 2 edges for 2, 1 edge for 4.
- Row 0 t=9'h1FF, b=7'h7F, other rows zero → `product`=1019. Row 3 only, same values → 65216 (16'hFEC0), `overflow`=0.
- All rows t=9'h1FF, b=7'h7F → `product`=16'h5257, `overflow`=1.
- Backpressure: `out_ready`=0 for 10 cycles after result. Required: `product`/`overflow` stable, `in_ready`=0, a second `in_valid` is not accepted; with `in_valid` held, it is accepted in the first IDLE cycle after the handshake and its result is correct.
- `rst` pulsed during the 2nd ACC cycle, then a new row set (row 1 t=9'h001, b=0) → no output for the aborted set; new result `product`=4, correct latency.
